// File: rtl/ad7606_emulator.sv
// ad7606_emulator
// Device-side model of an AD7606 parallel interface for loopback and bring-up
// builds. A CONVST rising edge starts an emulated conversion: BUSY is raised for
// CONV_CYCLES clocks and the eight channels captured at the start are then
// published to the result bank. The controller reads the results back one word
// per RD strobe while CS is low.
//
// Ports
//   sys_clk        system clock
//   rst_n          synchronous active-low reset (clears everything)
//   adc_reset      device RESET pin, active high (does not clear statistics)
//   adc_convst     conversion start pin
//   adc_cs_n       chip select pin, active low
//   adc_rd_n       read strobe pin, active low
//   adc_busy       BUSY, high for exactly CONV_CYCLES clocks per conversion
//   adc_data       parallel data bus, 16'h0000 while deselected
//   adc_data_oe    bus drive enable, follows the synchronized cs_n
//   pattern_en     1 = internal counting pattern, 0 = sample_in
//   sample_in      channel values, V1 = [15:0] ... V8 = [127:112]
//   conv_count     accepted conversions, wraps
//   overrun_count  CONVST edges ignored during BUSY, saturates at 255
//   fsm_state      debug view of the state register (0 idle, 1 conv, 2 ready)
//
// Read protocol: every pin is synchronized with two flops and edges are taken
// on the synchronized copies. With cs_n low, a falling rd_n edge loads
// adc_data from result[ptr] and the following rising rd_n edge advances ptr.
// A rising cs_n edge or the end of a conversion returns ptr to V1.
module ad7606_emulator #(
  parameter int FPGA_CLOCK_FREQ = 100,
  parameter int CONV_TIME_NS    = 4000
) (
  input  logic         sys_clk,
  input  logic         rst_n,
  input  logic         adc_reset,
  input  logic         adc_convst,
  input  logic         adc_cs_n,
  input  logic         adc_rd_n,
  output logic         adc_busy,
  output logic [15:0]  adc_data,
  output logic         adc_data_oe,
  input  logic         pattern_en,
  input  logic [127:0] sample_in,
  output logic [15:0]  conv_count,
  output logic [7:0]   overrun_count,
  output logic [1:0]   fsm_state
);

  localparam int CONV_RAW    = CONV_TIME_NS * FPGA_CLOCK_FREQ / 1000;
  localparam int CONV_CYCLES = (CONV_RAW < 1) ? 1 : CONV_RAW;
  localparam int CNT_W       = $clog2(CONV_CYCLES + 1);

  // Bit 0 of the encoding is BUSY itself, so adc_busy comes straight off a flop.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_CONV  = 2'b01,
    ST_READY = 2'b10
  } state_t;

  state_t state_q, state_d;

  // [0] first sync flop, [1] synchronized copy, [2] previous synchronized value
  logic [2:0] convst_sr, cs_sr, rd_sr;
  logic [1:0] reset_sr;

  logic convst_rise, cs_rise, rd_rise, rd_fall, dev_reset;
  logic accept, overrun_ev, eoc;

  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       ptr;
  logic [11:0]      pat_cnt;
  logic [15:0]      cap_bank [8];
  logic [15:0]      res_bank [8];

  // Synchronizers; reset values match the idle level of each pin so no
  // spurious edge is seen when reset releases.
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      convst_sr <= 3'b000;
      cs_sr     <= 3'b111;
      rd_sr     <= 3'b111;
      reset_sr  <= 2'b00;
    end else begin
      convst_sr <= {convst_sr[1:0], adc_convst};
      cs_sr     <= {cs_sr[1:0], adc_cs_n};
      rd_sr     <= {rd_sr[1:0], adc_rd_n};
      reset_sr  <= {reset_sr[0], adc_reset};
    end
  end

  assign convst_rise = convst_sr[1] & ~convst_sr[2];
  assign cs_rise     = cs_sr[1] & ~cs_sr[2];
  assign rd_rise     = rd_sr[1] & ~rd_sr[2];
  assign rd_fall     = ~rd_sr[1] & rd_sr[2];
  assign dev_reset   = reset_sr[1];

  // State register
  always_ff @(posedge sys_clk) begin
    if (!rst_n || dev_reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_READY: if (convst_rise) state_d = ST_CONV;
      ST_CONV:           if (cnt_q == CNT_W'(1)) state_d = ST_READY;
      default:           state_d = ST_IDLE;
    endcase
  end

  // Output / event decode
  always_comb begin
    adc_busy   = state_q[0];
    fsm_state  = state_q;
    accept     = (state_q != ST_CONV) && convst_rise && !dev_reset;
    overrun_ev = (state_q == ST_CONV) && convst_rise && !dev_reset;
    eoc        = (state_q == ST_CONV) && (cnt_q == CNT_W'(1));
  end

  // Datapath: banks, counters, read pointer and data bus
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      cnt_q         <= '0;
      ptr           <= 3'd0;
      pat_cnt       <= 12'd0;
      conv_count    <= 16'd0;
      overrun_count <= 8'd0;
      adc_data      <= 16'h0000;
      adc_data_oe   <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        cap_bank[i] <= 16'h0000;
        res_bank[i] <= 16'h0000;
      end
    end else begin
      adc_data_oe <= ~cs_sr[1];
      if (dev_reset) begin
        // Device reset aborts any conversion; statistics survive it.
        cnt_q    <= '0;
        ptr      <= 3'd0;
        adc_data <= 16'h0000;
        for (int i = 0; i < 8; i++) begin
          cap_bank[i] <= 16'h0000;
          res_bank[i] <= 16'h0000;
        end
      end else begin
        if (accept) begin
          for (int i = 0; i < 8; i++) begin
            cap_bank[i] <= pattern_en ? {pat_cnt, 4'(i + 1)} : sample_in[16*i +: 16];
          end
          cnt_q      <= CNT_W'(CONV_CYCLES);
          conv_count <= conv_count + 16'd1;
          pat_cnt    <= pat_cnt + 12'd1;
        end else if (state_q == ST_CONV && cnt_q != '0) begin
          cnt_q <= cnt_q - CNT_W'(1);
        end

        if (overrun_ev && overrun_count != 8'hFF) begin
          overrun_count <= overrun_count + 8'd1;
        end

        // End of conversion outranks both pointer updates from the bus.
        if (eoc) begin
          for (int i = 0; i < 8; i++) begin
            res_bank[i] <= cap_bank[i];
          end
          ptr <= 3'd0;
        end else if (cs_rise) begin
          ptr <= 3'd0;
        end else if (rd_rise && !cs_sr[1]) begin
          ptr <= ptr + 3'd1;
        end

        if (cs_sr[1]) begin
          adc_data <= 16'h0000;
        end else if (rd_fall) begin
          adc_data <= (state_q == ST_IDLE) ? 16'h0000 : res_bank[ptr];
        end
      end
    end
  end

endmodule

// File: doc/ad7606_emulator.md
# ad7606_emulator

Synthesizable model of the AD7606 device side of the parallel interface. It responds to CONVST with a BUSY pulse, then serves eight 16-bit channel results over CS/RD. The block sits in FPGA loopback and bring-up builds in place of the physical ADC, wired directly to the acquisition controller's ADC pins. Channel values come either from a sample input bus or from an internal counting pattern, so the capture path can be checked bit-exactly.

## Interface
- FPGA_CLOCK_FREQ, 100, sys_clk frequency [MHz]
- CONV_TIME_NS, 4000, emulated conversion time [ns]; CONV_CYCLES = CONV_TIME_NS*FPGA_CLOCK_FREQ/1000, minimum 1
- sys_clk  input  1  clock
- rst_n  input  1  reset; synchronous and active-low
- adc_reset  input  1  device RESET, active high
- adc_convst  input  1  conversion start; CONVST A and B tied together upstream
- adc_cs_n  input  1  chip select, active low
- adc_rd_n  input  1  read strobe, active low
- adc_busy  output  1  BUSY, high during conversion
- adc_data  output  16  parallel data bus
- adc_data_oe  output  1  bus drive enable; high while synced cs_n is low
- pattern_en  input  1  1 = internal pattern, 0 = sample_in
- sample_in  input  128  channel values; V1 = [15:0] … V8 = [127:112]
- conv_count  output  16  accepted conversions, wraps
- overrun_count  output  8  CONVST edges ignored during BUSY, saturates at 255

## Operation
- adc_convst, adc_cs_n, adc_rd_n and adc_reset each pass through a 2-flop synchronizer. Edges are detected on the synchronized copies.
- Two banks of 8x16 registers:
  - capture bank: loaded on an accepted CONVST rising edge.
  - result bank: copied from the capture bank at end of conversion.
- Reads always come from the result bank.
- Capture source:
  - pattern_en=0: sample_in.
  - pattern_en=1: channel k (1..8) = {pat_cnt[11:0], k[3:0]}. pat_cnt is 12-bit, increments after each accepted conversion, wraps 4095->0.
- States:
  - IDLE: no result yet.
  - CONV: busy high, counter running.
  - READY: result valid.
- IDLE/READY + CONVST rising edge -> CONV:
  - Capture the channels.
  - Load down-counter with CONV_CYCLES.
  - Increment conv_count.
- CONV: CONVST rising edge is ignored; overrun_count increments (saturating).
- CONV, counter reaches 0 -> READY: copy capture bank to result bank, clear read pointer ptr to 0.
- Read cycle (any state, synced cs_n low):
  - Synced rd_n falling edge: register adc_data <= result[ptr].
  - Synced rd_n rising edge: ptr <= ptr+1. ptr is 3-bit; the 9th read wraps back to V1.
- Reads in CONV return the previous result set. Reads in IDLE return 0.
- cs_n rising edge: ptr <= 0.
- Synced cs_n high: adc_data_oe=0 and adc_data is held at 16'h0000.
- Synced adc_reset high, or rst_n low:
  - State IDLE; busy 0; ptr 0; both banks cleared.
  - Counters cleared (rst_n only clears conv_count, overrun_count and pat_cnt).
  - CONVST is ignored while reset is held.
- rst_n asserted mid-conversion: busy drops on the next clock and no result is published.
- Simultaneous end-of-conversion and rd_n rising edge in the same cycle: the ptr clear wins (ptr=0).

## Timing
- Reset values: adc_busy=0, adc_data=16'h0000, adc_data_oe=0, conv_count=0, overrun_count=0.
- CONVST pin rising edge -> adc_busy high 3 sys_clk cycles later (2 sync + 1 register).
- adc_busy stays high exactly CONV_CYCLES cycles.
- Result bank and ptr update in the same cycle adc_busy falls.
- rd_n pin falling edge -> adc_data valid 3 cycles later.
- cs_n pin falling edge -> adc_data_oe high 3 cycles later.
- Controller requirements:
  - rd_n low >= 4 sys_clk cycles and high >= 3 sys_clk cycles.
  - Sample adc_data before the rd_n rising edge.
- All outputs are registered. There is no combinational path from any input to any output.

## Test plan
- rst_n low 5 cycles, then high -> all outputs at reset values; adc_busy stays 0 with no CONVST.
- CONV_TIME_NS=4000 at 100 MHz, pattern_en=1, one CONVST pulse -> adc_busy high for exactly 400 cycles starting 3 cycles after the edge. Eight reads return 16'h0001, 0002 … 0008. A second conversion returns 16'h0011 … 0018.
- pattern_en=0, sample_in = {16'h8000, 16'h7FFF, 16'h1234, 16'hABCD, 16'h0000, 16'hFFFF, 16'h5555, 16'hAAAA} -> reads return V1..V8 = AAAA, 5555, FFFF, 0000, ABCD, 1234, 7FFF, 8000.
- Three extra CONVST pulses during BUSY -> overrun_count=3, conv_count=1, busy width unchanged. 300 such pulses -> overrun_count=255.
- Reads issued during the 2nd conversion return the 1st result set. Nine reads in one CS window -> the 9th returns V1. Toggling cs_n resets ptr so the next read returns V1.
- adc_reset pulsed mid-conversion -> busy falls within 3 cycles, subsequent reads return 0, state IDLE. Then drive the reference acquisition controller against the emulator: its eight channel outputs match the pattern and adc_read_done pulses once per conversion.
